// File: rtl/slice_fetch_ctrl.sv
// rtl/slice_fetch_ctrl.sv - slice memory fetch sequencer for an 800x600 scan
//
// Samples the scan counters and, one cycle later, presents a registered fetch
// strobe plus slice select, column and in-slice row address for the four
// slice colour memories. A single running row/slice sequencer advances at
// every visible line end, so slice boundaries are contiguous.
//
// Ports:
//   clk              pixel clock
//   reset_n          synchronous active-low reset
//   enable           run control; low returns the block to idle
//   count_rgb        horizontal scan count, 0..H_TOTAL-1
//   reset_count_rgb  vertical scan count, 0..V_TOTAL-1
//   fetch_en         read strobe to the selected slice memory
//   slice_sel        selected slice memory
//   col_addr         column within the line (0 when not fetching)
//   row_addr         line within the current slice
//   line_start       pulse on column 0 of each visible line
//   frame_start      pulse on column 0 of line 0
//   sync_err         sticky horizontal counter discontinuity flag
//
// Optional feature macro: SYNC_CHECK_EN (horizontal count continuity checker;
// when undefined sync_err is tied low and the counts are trusted).

module slice_fetch_ctrl #(
  parameter int H_ACTIVE   = 800,
  parameter int H_TOTAL    = 1040,
  parameter int V_ACTIVE   = 600,
  parameter int V_TOTAL    = 666,
  parameter int SLICE_ROWS = 150,
  parameter int NUM_SLICES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [10:0] count_rgb,
  input  logic [9:0]  reset_count_rgb,
  output logic        fetch_en,
  output logic [1:0]  slice_sel,
  output logic [9:0]  col_addr,
  output logic [7:0]  row_addr,
  output logic        line_start,
  output logic        frame_start,
  output logic        sync_err
);

  localparam logic [10:0] H_ACT_C    = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST_VIS = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [7:0]  ROW_LAST   = 8'(SLICE_ROWS - 1);
  localparam logic [1:0]  SLICE_LAST = 2'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACTIVE,
    HBLANK,
    VBLANK
  } state_t;

  state_t      state_q, state_d;
  logic        fetch_d, line_d, frame_d;
  logic [9:0]  col_d;
  logic [7:0]  row_d;
  logic [1:0]  slice_d;
  logic        mismatch;
  logic        at_origin, at_line_end;

  assign at_origin   = (count_rgb == 11'd0) && (reset_count_rgb == 10'd0);
  assign at_line_end = (count_rgb == H_LAST);

`ifdef SYNC_CHECK_EN
  logic [10:0] prev_count;
  logic [10:0] expect_count;
  logic        sync_err_q;

  // The horizontal count must step by one and wrap after H_TOTAL-1; only
  // checked once the block has locked onto a frame.
  assign expect_count = (prev_count == H_LAST) ? 11'd0 : prev_count + 11'd1;
  assign mismatch     = (state_q != WAIT_FRAME) && (count_rgb != expect_count);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_count <= 11'd0;
      sync_err_q <= 1'b0;
    end else begin
      prev_count <= count_rgb;
      if (mismatch) sync_err_q <= 1'b1;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign mismatch = 1'b0;
  assign sync_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_addr;
    slice_d = slice_sel;

    case (state_q)
      WAIT_FRAME: begin
        if (at_origin) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (count_rgb == H_ACT_C) state_d = HBLANK;
      end
      HBLANK: begin
        if (at_line_end) begin
          if (reset_count_rgb == V_LAST_VIS) begin
            state_d = VBLANK;
            row_d   = 8'd0;
            slice_d = 2'd0;
          end else begin
            state_d = ACTIVE;
            if (row_addr == ROW_LAST) begin
              row_d   = 8'd0;
              slice_d = (slice_sel == SLICE_LAST) ? 2'd0 : slice_sel + 2'd1;
            end else begin
              row_d = row_addr + 8'd1;
            end
          end
        end
      end
      VBLANK: begin
        if (at_line_end && (reset_count_rgb == V_LAST)) state_d = ACTIVE;
      end
      default: state_d = WAIT_FRAME;
    endcase

    // Dropping enable or losing counter sync abandons the frame; re-entry
    // waits for the next frame origin.
    if (!enable || mismatch) begin
      state_d = WAIT_FRAME;
      row_d   = 8'd0;
      slice_d = 2'd0;
    end

    fetch_d = enable && !mismatch &&
              (((state_q == WAIT_FRAME) && at_origin) ||
               ((state_q == ACTIVE) && (count_rgb < H_ACT_C)));
    line_d  = fetch_d && (count_rgb == 11'd0);
    frame_d = line_d && (reset_count_rgb == 10'd0);
    col_d   = fetch_d ? count_rgb[9:0] : 10'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= WAIT_FRAME;
      fetch_en    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      col_addr    <= 10'd0;
      row_addr    <= 8'd0;
      slice_sel   <= 2'd0;
    end else begin
      state_q     <= state_d;
      fetch_en    <= fetch_d;
      line_start  <= line_d;
      frame_start <= frame_d;
      col_addr    <= col_d;
      row_addr    <= row_d;
      slice_sel   <= slice_d;
    end
  end

endmodule

// File: tb/tb_slice_fetch_ctrl.sv
// tb/tb_slice_fetch_ctrl.sv - directed self-checking bench for slice_fetch_ctrl

module tb_slice_fetch_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable;
  logic [10:0] count_rgb;
  logic [9:0]  reset_count_rgb;
  logic        fetch_en, line_start, frame_start, sync_err;
  logic [1:0]  slice_sel;
  logic [9:0]  col_addr;
  logic [7:0]  row_addr;

  logic        s_enable;
  logic [10:0] s_h;
  logic [9:0]  s_v;
  logic        s_fetch_en, s_line_start, s_frame_start, s_sync_err;
  logic [1:0]  s_slice_sel;
  logic [9:0]  s_col_addr;
  logic [7:0]  s_row_addr;

  int n_assert = 0;
  int n_fail   = 0;

  slice_fetch_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .count_rgb       (count_rgb),
    .reset_count_rgb (reset_count_rgb),
    .fetch_en        (fetch_en),
    .slice_sel       (slice_sel),
    .col_addr        (col_addr),
    .row_addr        (row_addr),
    .line_start      (line_start),
    .frame_start     (frame_start),
    .sync_err        (sync_err)
  );

  // Scaled-down timing so a complete frame fits in a short run.
  slice_fetch_ctrl #(
    .H_ACTIVE   (8),
    .H_TOTAL    (12),
    .V_ACTIVE   (8),
    .V_TOTAL    (10),
    .SLICE_ROWS (2),
    .NUM_SLICES (4)
  ) dut_small (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (s_enable),
    .count_rgb       (s_h),
    .reset_count_rgb (s_v),
    .fetch_en        (s_fetch_en),
    .slice_sel       (s_slice_sel),
    .col_addr        (s_col_addr),
    .row_addr        (s_row_addr),
    .line_start      (s_line_start),
    .frame_start     (s_frame_start),
    .sync_err        (s_sync_err)
  );

  logic [22:0] main_obs, s_obs;
  assign main_obs = {fetch_en, line_start, frame_start, slice_sel, col_addr, row_addr};
  assign s_obs    = {s_fetch_en, s_line_start, s_frame_start, s_slice_sel, s_col_addr, s_row_addr};

  function automatic logic [22:0] pk(input logic fe, input logic ls, input logic fs,
                                     input int sl, input int col, input int row);
    return {fe, ls, fs, 2'(sl), 10'(col), 8'(row)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick(input int h, input int v);
    count_rgb       = 11'(h);
    reset_count_rgb = 10'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic s_tick(input int h, input int v);
    s_h = 11'(h);
    s_v = 10'(v);
    @(posedge clk);
    #1;
  endtask

  int fetches, s_fetches, s_frames, s_lines;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    s_enable = 1'b0;
    s_h = '0;
    s_v = '0;
    tick(0, 0);
    tick(0, 0);
    chk("reset_outputs", main_obs, 0);
    chk("reset_sync_err", sync_err, 0);

    reset_n = 1'b1;
    enable  = 1'b1;
    tick(0, 0);
    chk("frame_origin", main_obs, pk(1, 1, 1, 0, 0, 0));
    fetches = 1;
    for (int h = 1; h < 1040; h++) begin
      tick(h, 0);
      if (fetch_en) fetches++;
      chk("line0_sweep", main_obs,
          pk(h < 800, 0, 0, 0, (h < 800) ? h : 0, (h == 1039) ? 1 : 0));
    end
    chk("line0_fetch_count", fetches, 800);

`ifndef SYNC_CHECK_EN
    // Counts are trusted here, so each visible line is compressed to its
    // three decision points: column 0, H_ACTIVE and H_TOTAL-1.
    for (int v = 1; v < 600; v++) begin
      tick(0, v);
      chk("line_head", main_obs, pk(1, 1, 0, v / 150, 0, v % 150));
      tick(800, v);
      tick(1039, v);
    end
    chk("vblank_entry", main_obs, 0);
    for (int v = 600; v < 666; v++) begin
      tick(0, v);
      chk("vblank_idle", main_obs, 0);
      tick(1039, v);
    end
    tick(0, 0);
    chk("next_frame", main_obs, pk(1, 1, 1, 0, 0, 0));
    tick(800, 0);
    tick(1039, 0);
    for (int v = 1; v < 200; v++) begin
      tick(0, v);
      tick(800, v);
      tick(1039, v);
    end
    tick(0, 200);
    tick(400, 200);
    chk("pre_drop", main_obs, pk(1, 0, 0, 1, 400, 50));
    enable = 1'b0;
    tick(401, 200);
    chk("enable_drop", main_obs, 0);
    enable = 1'b1;
    tick(402, 200);
    chk("reraise_midline", main_obs, 0);
    tick(1039, 200);
    tick(0, 201);
    chk("no_midframe_reentry", main_obs, 0);
    tick(0, 0);
    chk("reentry_origin", main_obs, pk(1, 1, 1, 0, 0, 0));
    reset_n = 1'b0;
    tick(1, 0);
    chk("reset_wins", main_obs, 0);
    reset_n = 1'b1;
    tick(2, 0);
    chk("reset_stays_idle", main_obs, 0);
`else
    for (int v = 1; v < 5; v++)
      for (int h = 0; h < 1040; h++) tick(h, v);
    for (int h = 0; h <= 100; h++) tick(h, 5);
    chk("pre_jump", main_obs, pk(1, 0, 0, 0, 100, 5));
    chk("pre_jump_sync_err", sync_err, 0);
    tick(300, 5);
    chk("jump_outputs", main_obs, 0);
    chk("jump_sync_err", sync_err, 1);
    for (int h = 301; h < 306; h++) tick(h, 5);
    chk("jump_idle", main_obs, 0);
    tick(0, 0);
    chk("resume_origin", main_obs, pk(1, 1, 1, 0, 0, 0));
    chk("sync_err_sticky", sync_err, 1);
    reset_n = 1'b0;
    tick(1, 0);
    chk("sync_err_reset", sync_err, 0);
    reset_n = 1'b1;
`endif

    enable = 1'b0;
    s_enable = 1'b1;
    s_fetches = 0;
    s_frames = 0;
    s_lines = 0;
    for (int v = 0; v < 10; v++) begin
      for (int h = 0; h < 12; h++) begin
        s_tick(h, v);
        if (s_fetch_en) s_fetches++;
        if (s_frame_start) s_frames++;
        if (s_line_start) s_lines++;
        if (v >= 8)
          chk("small_vblank", s_obs, 0);
        else if (h < 8)
          chk("small_fetch", s_obs, pk(1, h == 0, (h == 0) && (v == 0), v / 2, h, v % 2));
      end
    end
    chk("small_fetch_total", s_fetches, 64);
    chk("small_frame_total", s_frames, 1);
    chk("small_line_total", s_lines, 8);
    chk("small_sync_err", s_sync_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
